// File: rtl/count_display.sv
// ============================================================================
// count_display : 16-bit binary to 4-digit BCD with multiplexed 7-seg drive
// Revision 1.0
// ============================================================================
`default_nettype none

module count_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] count,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  LED_out,
  output logic [3:0]  anode_select
);

  localparam logic [19:0] REFRESH_LAST = 20'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  // {bcd scratch[35:16], binary[15:0]} shifted as one vector
  logic [35:0]       r_dd, w_dd_nxt;
  logic [3:0]        r_shift_cnt, w_shift_cnt_nxt;
  logic [3:0][3:0]   r_digits, w_digits_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic [19:0]       w_adj;

  logic [19:0]       r_refresh;
  logic [1:0]        r_digit_idx;

  logic [3:0]        w_digit;
  logic              w_blank;

  // ---------------------------------------------------------------------------
  // Conversion FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dd        <= '0;
      r_shift_cnt <= '0;
      r_digits    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dd        <= w_dd_nxt;
      r_shift_cnt <= w_shift_cnt_nxt;
      r_digits    <= w_digits_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_adj = r_dd[35:16];
    for (int i = 0; i < 5; i++) begin
      if (r_dd[16 + 4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_dd[16 + 4*i +: 4] + 4'd3;
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM: next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_dd_nxt        = r_dd;
    w_shift_cnt_nxt = r_shift_cnt;
    w_digits_nxt    = r_digits;
    w_overflow_nxt  = r_overflow;

    unique case (r_state)
      IDLE: begin
        if (load) begin
          w_dd_nxt        = {20'd0, count};
          w_shift_cnt_nxt = 4'd0;
          w_state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        w_dd_nxt        = {w_adj, r_dd[15:0]} << 1;
        w_shift_cnt_nxt = r_shift_cnt + 4'd1;
        if (r_shift_cnt == 4'd15)
          w_state_nxt = DONE;
      end
      DONE: begin
        // A fifth BCD digit means the value cannot be shown: saturate at 9999
        if (r_dd[35:32] != 4'd0) begin
          w_digits_nxt   = {4'd9, 4'd9, 4'd9, 4'd9};
          w_overflow_nxt = 1'b1;
        end else begin
          w_digits_nxt   = r_dd[31:16];
          w_overflow_nxt = 1'b0;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // Free-running digit scan
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh   <= '0;
      r_digit_idx <= '0;
    end else if (r_refresh == REFRESH_LAST) begin
      r_refresh   <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_refresh   <= r_refresh + 20'd1;
    end
  end

  always_comb begin
    w_digit = r_digits[r_digit_idx];
    w_blank = 1'b0;
    unique case (r_digit_idx)
      2'd3:    w_blank = (r_digits[3] == 4'd0);
      2'd2:    w_blank = (r_digits[3] == 4'd0) && (r_digits[2] == 4'd0);
      2'd1:    w_blank = (r_digits[3] == 4'd0) && (r_digits[2] == 4'd0) &&
                         (r_digits[1] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end

  always_comb begin
    anode_select = 4'b1110;
    unique case (r_digit_idx)
      2'd0:    anode_select = 4'b1110;
      2'd1:    anode_select = 4'b1101;
      2'd2:    anode_select = 4'b1011;
      default: anode_select = 4'b0111;
    endcase
  end

  // Segment order {a,b,c,d,e,f,g}, active-low
  always_comb begin
    LED_out = 7'b1111111;
    if (!w_blank) begin
      unique case (w_digit)
        4'd0:    LED_out = 7'b0000001;
        4'd1:    LED_out = 7'b1001111;
        4'd2:    LED_out = 7'b0010010;
        4'd3:    LED_out = 7'b0000110;
        4'd4:    LED_out = 7'b1001100;
        4'd5:    LED_out = 7'b0100100;
        4'd6:    LED_out = 7'b0100000;
        4'd7:    LED_out = 7'b0001111;
        4'd8:    LED_out = 7'b0000000;
        4'd9:    LED_out = 7'b0000100;
        default: LED_out = 7'b1111111;
      endcase
    end
  end

endmodule

`default_nettype wire
